// File: rtl/circuit01_sweep_ctrl.sv
// rtl/circuit01_sweep_ctrl.sv - self-checking stimulus sequencer for the circuit01 datapath
//
// Walks {A,B,C} through all eight combinations in ascending order. Each
// vector is held for HOLD_CYCLES clocks. D is sampled on the last clock of
// each hold and compared against the GOLDEN truth table.
//
// Parameters:
//   HOLD_CYCLES  clocks each vector is held before D is sampled (1..15)
//   GOLDEN       expected D per vector index {A,B,C}, bit i for index i
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request a sweep (honoured in IDLE only)
//   abort        terminate a running sweep (honoured in APPLY only)
//   d_in         D output of circuit01
//   a_out/b_out/c_out  circuit01 inputs, equal to the vector index while applying
//   busy         high while a sweep is applying vectors
//   done         one-cycle pulse when a sweep completes
//   result       captured D, bit i = D sampled for vector i
//   err_cnt      number of vectors whose D differed from GOLDEN
//   pass         last completed sweep had no mismatches
module circuit01_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 5,
    parameter logic [7:0]  GOLDEN      = 8'hF1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       d_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] err_cnt,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_e     state_q;
    logic [2:0] vec_q;
    logic [3:0] hold_cnt_q;
    logic [2:0] abc_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] result_q;
    logic [3:0] err_cnt_q;
    logic       pass_q;

    logic       sample_due;
    logic       mismatch;
    logic [3:0] err_cnt_d;
    logic [2:0] vec_d;

    assign sample_due = (hold_cnt_q == HOLD_LAST);
    assign mismatch   = d_in ^ GOLDEN[vec_q];
    // Count including the sample being taken this edge; pass on DONE entry
    // must see the final vector's contribution.
    assign err_cnt_d  = err_cnt_q + {3'b000, mismatch};
    assign vec_d      = vec_q + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= 3'd0;
            hold_cnt_q <= 4'd0;
            abc_q      <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 8'h00;
            err_cnt_q  <= 4'd0;
            pass_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= APPLY;
                        vec_q      <= 3'd0;
                        hold_cnt_q <= 4'd0;
                        abc_q      <= 3'b000;
                        busy_q     <= 1'b1;
                        result_q   <= 8'h00;
                        err_cnt_q  <= 4'd0;
                        pass_q     <= 1'b0;
                    end
                end

                APPLY: begin
                    if (abort) begin
                        // Abort beats a coincident sample; partial results stay.
                        state_q    <= IDLE;
                        vec_q      <= 3'd0;
                        hold_cnt_q <= 4'd0;
                        abc_q      <= 3'b000;
                        busy_q     <= 1'b0;
                    end else if (sample_due) begin
                        result_q[vec_q] <= d_in;
                        err_cnt_q       <= err_cnt_d;
                        hold_cnt_q      <= 4'd0;
                        if (vec_q == 3'd7) begin
                            state_q <= DONE;
                            vec_q   <= 3'd0;
                            abc_q   <= 3'b000;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == 4'd0);
                        end else begin
                            vec_q <= vec_d;
                            abc_q <= vec_d;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end

                DONE: begin
                    // Start is deliberately not looked at here.
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    abc_q   <= 3'b000;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out   = abc_q[2];
    assign b_out   = abc_q[1];
    assign c_out   = abc_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign err_cnt = err_cnt_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_circuit01_sweep_ctrl.sv
// tb/tb_circuit01_sweep_ctrl.sv - directed and randomized bench for circuit01_sweep_ctrl
module tb_circuit01_sweep_ctrl;

    localparam logic [7:0] GOLD = 8'hF1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort;
    logic       sel;
    int         hc;
    int         mode;
    logic [7:0] pat;

    logic       start5, abort5, d5, a5, b5, c5, busy5, done5, pass5;
    logic [7:0] res5;
    logic [3:0] err5;
    logic       start1, abort1, d1, a1, b1, c1, busy1, done1, pass1;
    logic [7:0] res1;
    logic [3:0] err1;

    logic       busy_o, done_o, pass_o;
    logic [2:0] abc_o;
    logic [7:0] res_o;
    logic [3:0] err_o;

    int checks = 0;
    int errors = 0;

    assign start5 = start & ~sel;
    assign abort5 = abort & ~sel;
    assign start1 = start & sel;
    assign abort1 = abort & sel;

    assign busy_o = sel ? busy1 : busy5;
    assign done_o = sel ? done1 : done5;
    assign pass_o = sel ? pass1 : pass5;
    assign abc_o  = sel ? {a1, b1, c1} : {a5, b5, c5};
    assign res_o  = sel ? res1 : res5;
    assign err_o  = sel ? err1 : err5;

    // D source: real circuit01, tied low, tied high, or random truth table
    always_comb begin
        d5 = 1'b0;
        case (mode)
            0:       d5 = ~(~a5 & (b5 | c5));
            1:       d5 = 1'b0;
            2:       d5 = 1'b1;
            default: d5 = pat[{a5, b5, c5}];
        endcase
    end

    always_comb begin
        d1 = 1'b0;
        case (mode)
            0:       d1 = ~(~a1 & (b1 | c1));
            1:       d1 = 1'b0;
            2:       d1 = 1'b1;
            default: d1 = pat[{a1, b1, c1}];
        endcase
    end

    circuit01_sweep_ctrl #(.HOLD_CYCLES(5), .GOLDEN(8'hF1)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .abort(abort5), .d_in(d5),
        .a_out(a5), .b_out(b5), .c_out(c5), .busy(busy5), .done(done5),
        .result(res5), .err_cnt(err5), .pass(pass5)
    );

    circuit01_sweep_ctrl #(.HOLD_CYCLES(1), .GOLDEN(8'hF1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .d_in(d1),
        .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1),
        .result(res1), .err_cnt(err1), .pass(pass1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected D for vector v from the stimulus source, at truth-table level
    function automatic logic model_d(input int v);
        logic a_bit, bc_bit;
        a_bit  = (v >= 4);
        bc_bit = ((v % 4) != 0);
        case (mode)
            0:       return !(!a_bit && bc_bit);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return pat[v];
        endcase
    endfunction

    function automatic int popcount(input logic [7:0] x);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(x[i]);
        return n;
    endfunction

    // One sweep from an IDLE cycle; abort_at < 0 means run to completion.
    task automatic sweep(input int abort_at, input bit repulse);
        logic [7:0] exp_d;
        logic [7:0] mask;
        int         n;
        int         ne;
        for (int v = 0; v < 8; v++) exp_d[v] = model_d(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_result_clr", res_o, 0);
        chk("accept_err_clr", err_o, 0);
        chk("accept_pass_clr", pass_o, 0);
        for (int k = 0; k < 8 * hc; k++) begin
            chk("busy_apply", busy_o, 1);
            chk("abc_step", abc_o, k / hc);
            chk("done_early", done_o, 0);
            if (k == abort_at) abort = 1'b1;
            if (repulse && k == 10) start = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            if (k == abort_at) begin
                n    = k / hc;
                mask = 8'((1 << n) - 1);
                ne   = popcount((exp_d ^ GOLD) & mask);
                chk("abort_busy", busy_o, 0);
                chk("abort_abc", abc_o, 0);
                chk("abort_done", done_o, 0);
                chk("abort_result", res_o, exp_d & mask);
                chk("abort_err", err_o, ne);
                chk("abort_pass", pass_o, 0);
                repeat (2) begin
                    tick();
                    chk("abort_no_done", done_o, 0);
                    chk("abort_idle_busy", busy_o, 0);
                end
                return;
            end
        end
        ne = popcount(exp_d ^ GOLD);
        chk("done_pulse", done_o, 1);
        chk("done_busy", busy_o, 0);
        chk("done_abc", abc_o, 0);
        chk("done_result", res_o, exp_d);
        chk("done_err", err_o, ne);
        chk("done_pass", pass_o, (ne == 0) ? 1 : 0);
        if (repulse) start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_single", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_result_hold", res_o, exp_d);
        chk("idle_pass_hold", pass_o, (ne == 0) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sel   = 1'b0;
        hc    = 5;
        mode  = 0;
        pat   = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_abc", abc_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", res_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_busy_h1", busy1, 0);
        tick();

        // Real circuit, tied low, tied high
        mode = 0; sweep(-1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", busy_o, 0);
        chk("idle_abort_pass", pass_o, 1);
        chk("idle_abort_result", res_o, 8'hF1);
        mode = 1; sweep(-1, 1'b0);
        mode = 2; sweep(-1, 1'b0);

        // Abort during vector 3, then a clean sweep
        mode = 0; sweep(17, 1'b0);
        sweep(-1, 1'b0);

        // Ignored restarts, then an immediate second sweep
        sweep(-1, 1'b1);
        sweep(-1, 1'b0);

        // Random truth tables with optional random abort point
        mode = 3;
        for (int i = 0; i < 8; i++) begin
            pat = 8'($urandom);
            if ($urandom_range(0, 1) == 1) sweep(int'($urandom_range(0, 39)), 1'b0);
            else sweep(-1, 1'b0);
        end

        // Mid-sweep reset
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (23) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_abc", abc_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_result", res_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_pass", pass_o, 0);
        repeat (3) begin
            tick();
            chk("midrst_no_done", done_o, 0);
            chk("midrst_idle", busy_o, 0);
        end

        // Single-cycle hold build
        sel = 1'b1;
        hc  = 1;
        tick();
        mode = 0; sweep(-1, 1'b0);
        mode = 1; sweep(-1, 1'b0);
        mode = 3;
        for (int i = 0; i < 4; i++) begin
            pat = 8'($urandom);
            if ($urandom_range(0, 1) == 1) sweep(int'($urandom_range(0, 7)), 1'b0);
            else sweep(-1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
